// File: rtl/butterfly_inverse.sv
// Inverse radix-2 butterfly: recovers A = (P+M)/2 and B = conj(W)*(P-M)/2 from a
// butterfly output pair, reusing one signed HALF x HALF multiplier over four cycles.
module butterfly_inverse #(
    parameter int WIDTH = 8,
    parameter int FRAC  = WIDTH/2 - 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] plus_in,
    input  logic [WIDTH-1:0] minus_in,
    input  logic [WIDTH-1:0] w_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] a_out,
    output logic [WIDTH-1:0] b_out,
    output logic             busy
);

    localparam int HALF = WIDTH / 2;
    localparam int ACCW = 2 * HALF + 1;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MUL0 = 3'd1,
        MUL1 = 3'd2,
        MUL2 = 3'd3,
        MUL3 = 3'd4,
        DONE = 3'd5
    } state_t;

    state_t state_q, state_d;

    logic signed [HALF-1:0] ar_q, ar_d;
    logic signed [HALF-1:0] ai_q, ai_d;
    logic signed [HALF-1:0] dr_q, dr_d;
    logic signed [HALF-1:0] di_q, di_d;
    logic signed [HALF-1:0] wr_q, wr_d;
    logic signed [HALF-1:0] wi_q, wi_d;
    logic signed [ACCW-1:0] acc_re_q, acc_re_d;
    logic signed [ACCW-1:0] acc_im_q, acc_im_d;
    logic [WIDTH-1:0]       a_out_q, a_out_d;
    logic [WIDTH-1:0]       b_out_q, b_out_d;

    logic signed [HALF-1:0]   pr, pi, mr, mi;
    logic signed [HALF:0]     sum_re, sum_im, dif_re, dif_im;
    logic signed [HALF-1:0]   op_a, op_b;
    logic signed [2*HALF-1:0] prod;
    logic signed [ACCW-1:0]   prod_ext;

    assign pr = plus_in[WIDTH-1:HALF];
    assign pi = plus_in[HALF-1:0];
    assign mr = minus_in[WIDTH-1:HALF];
    assign mi = minus_in[HALF-1:0];

    // One extra bit keeps P+M and P-M exact before the halving shift.
    assign sum_re = {pr[HALF-1], pr} + {mr[HALF-1], mr};
    assign sum_im = {pi[HALF-1], pi} + {mi[HALF-1], mi};
    assign dif_re = {pr[HALF-1], pr} - {mr[HALF-1], mr};
    assign dif_im = {pi[HALF-1], pi} - {mi[HALF-1], mi};

    // Operand select for the single shared multiplier.
    always_comb begin
        op_a = wr_q;
        op_b = dr_q;
        case (state_q)
            MUL1: begin
                op_a = wi_q;
                op_b = di_q;
            end
            MUL2: begin
                op_a = wr_q;
                op_b = di_q;
            end
            MUL3: begin
                op_a = wi_q;
                op_b = dr_q;
            end
            default: begin
                op_a = wr_q;
                op_b = dr_q;
            end
        endcase
    end

    assign prod     = op_a * op_b;
    assign prod_ext = {prod[2*HALF-1], prod};

    always_comb begin
        state_d  = state_q;
        ar_d     = ar_q;
        ai_d     = ai_q;
        dr_d     = dr_q;
        di_d     = di_q;
        wr_d     = wr_q;
        wi_d     = wi_q;
        acc_re_d = acc_re_q;
        acc_im_d = acc_im_q;
        a_out_d  = a_out_q;
        b_out_d  = b_out_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    // Dropping the LSB of the HALF+1 bit value is an arithmetic floor halving.
                    ar_d    = sum_re[HALF:1];
                    ai_d    = sum_im[HALF:1];
                    dr_d    = dif_re[HALF:1];
                    di_d    = dif_im[HALF:1];
                    wr_d    = w_in[WIDTH-1:HALF];
                    wi_d    = w_in[HALF-1:0];
                    state_d = MUL0;
                end
            end
            MUL0: begin
                acc_re_d = prod_ext;
                state_d  = MUL1;
            end
            MUL1: begin
                acc_re_d = acc_re_q + prod_ext;
                state_d  = MUL2;
            end
            MUL2: begin
                acc_im_d = prod_ext;
                state_d  = MUL3;
            end
            MUL3: begin
                acc_im_d = acc_im_q - prod_ext;
                a_out_d  = {ar_q, ai_q};
                b_out_d  = {acc_re_q[HALF+FRAC-1:FRAC], acc_im_d[HALF+FRAC-1:FRAC]};
                state_d  = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            ar_q     <= '0;
            ai_q     <= '0;
            dr_q     <= '0;
            di_q     <= '0;
            wr_q     <= '0;
            wi_q     <= '0;
            acc_re_q <= '0;
            acc_im_q <= '0;
            a_out_q  <= '0;
            b_out_q  <= '0;
        end else begin
            state_q  <= state_d;
            ar_q     <= ar_d;
            ai_q     <= ai_d;
            dr_q     <= dr_d;
            di_q     <= di_d;
            wr_q     <= wr_d;
            wi_q     <= wi_d;
            acc_re_q <= acc_re_d;
            acc_im_q <= acc_im_d;
            a_out_q  <= a_out_d;
            b_out_q  <= b_out_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign a_out     = a_out_q;
    assign b_out     = b_out_q;

    // Bits discarded by the halving shift and by result truncation/wrap.
    logic unused_bits;
    assign unused_bits = ^{sum_re[0], sum_im[0], dif_re[0], dif_im[0],
                           acc_re_q[ACCW-1:HALF+FRAC], acc_re_q[FRAC-1:0],
                           acc_im_d[ACCW-1:HALF+FRAC], acc_im_d[FRAC-1:0]};

endmodule

// File: tb/tb_butterfly_inverse.sv
// Scoreboard bench for butterfly_inverse: directed vectors, backpressure,
// mid-operation reset and randomized operations against an integer model.
module tb_butterfly_inverse;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] plus_in;
    logic [7:0] minus_in;
    logic [7:0] w_in;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] a_out;
    logic [7:0] b_out;
    logic       busy;

    int n_checks;
    int n_fail;
    logic [15:0] exp_q[$];

    butterfly_inverse #(.WIDTH(8), .FRAC(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .plus_in   (plus_in),
        .minus_in  (minus_in),
        .w_in      (w_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .a_out     (a_out),
        .b_out     (b_out),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Integer reference: A = floor((P+M)/2), D = floor((P-M)/2), B = conj(W)*D scaled by 2^-3, wrapped to 4 bits.
    function automatic logic [15:0] model(input logic [7:0] p, input logic [7:0] m, input logic [7:0] w);
        int pr, pi, mr, mi, wr, wi, ar, ai, dr, di, acc_re, acc_im;
        logic [3:0] ra, ia, rb, ib;
        pr = $signed(p[7:4]);
        pi = $signed(p[3:0]);
        mr = $signed(m[7:4]);
        mi = $signed(m[3:0]);
        wr = $signed(w[7:4]);
        wi = $signed(w[3:0]);
        ar = (pr + mr) >>> 1;
        ai = (pi + mi) >>> 1;
        dr = (pr - mr) >>> 1;
        di = (pi - mi) >>> 1;
        acc_re = wr * dr + wi * di;
        acc_im = wr * di - wi * dr;
        ra = 4'(ar);
        ia = 4'(ai);
        rb = 4'(acc_re >>> 3);
        ib = 4'(acc_im >>> 3);
        return {ra, ia, rb, ib};
    endfunction

    task automatic scramble_inputs();
        plus_in  = 8'($urandom);
        minus_in = 8'($urandom);
        w_in     = 8'($urandom);
    endtask

    // noise: keep in_valid high with changing data while busy, and leave the basic
    // vector presented at the output handshake so IDLE accepts it next.
    task automatic do_op(input logic [7:0] p, input logic [7:0] m, input logic [7:0] w,
                         input logic [15:0] exp, input int stall, input bit noise);
        int cyc;
        logic [15:0] held;
        logic [15:0] e;
        cyc = 0;
        while (!in_ready && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("in_ready_idle", in_ready, 1);
        in_valid  = 1'b1;
        plus_in   = p;
        minus_in  = m;
        w_in      = w;
        out_ready = 1'b1;
        @(posedge clk); #1;
        exp_q.push_back(exp);
        cyc = 1;
        if (noise) scramble_inputs();
        else in_valid = 1'b0;
        while (!out_valid && cyc < 20) begin
            check("in_ready_busy", in_ready, 0);
            @(posedge clk); #1;
            cyc++;
            if (noise) scramble_inputs();
        end
        check("out_valid_rise", out_valid, 1);
        check("latency", cyc, 5);
        held = {a_out, b_out};
        if (stall > 0) out_ready = 1'b0;
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            cyc++;
            if (noise) scramble_inputs();
            check("hold_data", {a_out, b_out}, held);
            check("hold_valid", out_valid, 1);
            check("hold_ready_low", in_ready, 0);
        end
        out_ready = 1'b1;
        if (noise) begin
            plus_in  = 8'h64;
            minus_in = 8'h22;
            w_in     = 8'h40;
        end
        e = exp_q.pop_front();
        check("a_out", a_out, e[15:8]);
        check("b_out", b_out, e[7:0]);
        $display("op P=%h M=%h W=%h stall=%0d -> a=%h b=%h (exp a=%h b=%h)",
                 p, m, w, stall, a_out, b_out, e[15:8], e[7:0]);
        @(posedge clk); #1;
        cyc++;
        check("out_valid_drop", out_valid, 0);
        check("in_ready_back", in_ready, 1);
        check("a_out_kept", a_out, e[15:8]);
        check("b_out_kept", b_out, e[7:0]);
        if (stall == 0) check("init_interval", cyc, 6);
        if (!noise) in_valid = 1'b0;
    endtask

    initial begin
        int cyc;
        logic [7:0] rp, rm, rw;
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        plus_in   = '0;
        minus_in  = '0;
        w_in      = '0;
        #12;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_a_out", a_out, 0);
        check("rst_b_out", b_out, 0);
        @(negedge clk);
        rst = 1'b0;

        do_op(8'h64, 8'h22, 8'h40, 16'h4310, 0, 1'b0);
        do_op(8'h64, 8'h22, 8'h08, 16'h43F2, 0, 1'b0);
        do_op(8'hF0, 8'h00, 8'h40, 16'hF0F0, 0, 1'b0);
        do_op(8'h88, 8'h77, 8'h88, 16'hFF00, 0, 1'b0);
        do_op(8'hF0, 8'h00, 8'h40, 16'hF0F0, 10, 1'b1);
        do_op(8'h64, 8'h22, 8'h40, 16'h4310, 0, 1'b0);

        // Abort in MUL2 with asynchronous reset.
        in_valid  = 1'b1;
        plus_in   = 8'h88;
        minus_in  = 8'h77;
        w_in      = 8'h88;
        out_ready = 1'b1;
        @(posedge clk); #1;
        exp_q.push_back(16'hFF00);
        in_valid = 1'b0;
        cyc = 1;
        while (cyc < 3) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("pre_rst_busy", busy, 1);
        rst = 1'b1;
        #1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_a_out", a_out, 0);
        check("mid_rst_b_out", b_out, 0);
        void'(exp_q.pop_back());
        @(negedge clk);
        rst = 1'b0;
        do_op(8'h64, 8'h22, 8'h08, 16'h43F2, 0, 1'b0);

        for (int i = 0; i < 16; i++) begin
            rp = 8'($urandom);
            rm = 8'($urandom);
            rw = 8'($urandom);
            do_op(rp, rm, rw, model(rp, rm, rw), int'($urandom_range(0, 2)), 1'b0);
        end

        check("scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
